// File: rtl/color_blob_pkg.sv
// color_blob_pkg
// Shared definitions for the multi-channel colour blob tracker:
//   - frame_state_t : states of the shared frame sequencing FSM
//   - DEFAULT_H_ACTIVE / DEFAULT_V_ACTIVE : default raster size; the
//     fallback object centre is half of each dimension
//   - center_of()   : centre column of a run, given its start and length
package color_blob_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    LINE_WAIT,
    IN_LINE,
    PUBLISH
  } frame_state_t;

  localparam int DEFAULT_H_ACTIVE = 640;
  localparam int DEFAULT_V_ACTIVE = 480;

  // Centre of a run of len pixels starting at start. Even-length runs
  // resolve to the left of the two middle pixels. Callers truncate the
  // result to their coordinate width, which gives modulo-2^XW arithmetic.
  function automatic int unsigned center_of(input int unsigned start,
                                            input int unsigned len);
    return start + ((len - 1) >> 1);
  endfunction

endpackage

// File: rtl/blob_channel.sv
// blob_channel
// Run tracking, per-frame accumulators and empty-frame hold logic for one
// colour channel.
// Ports:
//   VGA_clock, reset   pixel clock, asynchronous active-low reset
//   clear              frame FSM is idle: drop all per-frame accumulators
//   in_line            frame FSM is inside an active line
//   line_active        iVgaHRequest && iVgaVRequest this cycle
//   publish            frame FSM is publishing: load the result registers
//   mask_bit           this channel's filtered colour bit
//   x_cont, y_cont     raster position of mask_bit
//   found ... bbox_y1  published results, stable for a whole frame
module blob_channel
  import color_blob_pkg::*;
#(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int H_ACTIVE    = DEFAULT_H_ACTIVE,
  parameter int V_ACTIVE    = DEFAULT_V_ACTIVE,
  parameter int MIN_RUN     = 4,
  parameter int HOLD_FRAMES = 3
) (
  input  logic          VGA_clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_line,
  input  logic          line_active,
  input  logic          publish,
  input  logic          mask_bit,
  input  logic [XW-1:0] x_cont,
  input  logic [YW-1:0] y_cont,
  output logic          found,
  output logic [XW-1:0] center_x,
  output logic [YW-1:0] center_y,
  output logic [XW-1:0] max_run,
  output logic [XW-1:0] bbox_x0,
  output logic [XW-1:0] bbox_x1,
  output logic [YW-1:0] bbox_y0,
  output logic [YW-1:0] bbox_y1
);

  localparam int MW = $clog2(HOLD_FRAMES + 1) + 1;
  localparam logic [XW-1:0] DEF_CX    = XW'(H_ACTIVE / 2);
  localparam logic [YW-1:0] DEF_CY    = YW'(V_ACTIVE / 2);
  localparam logic [XW-1:0] MIN_RUN_X = XW'(MIN_RUN);
  localparam logic [MW-1:0] HOLD_M    = MW'(HOLD_FRAMES);

  logic [XW-1:0] run_len, run_start, run_end, cand_cx;
  logic [XW-1:0] best_len, best_cx;
  logic [YW-1:0] best_y;
  logic          acc_any;
  logic [XW-1:0] acc_x0, acc_x1;
  logic [YW-1:0] acc_y0, acc_y1;
  logic [MW-1:0] miss_cnt, miss_next;
  logic          extend, close_run, qualify, revert;

  // A run is open whenever run_len is non-zero; it closes on the first
  // in-line cycle that does not extend it, including the line-exit cycle.
  always_comb begin
    extend    = in_line && line_active && mask_bit;
    close_run = in_line && !extend && (run_len != '0);
    qualify   = close_run && (run_len >= MIN_RUN_X);
    run_end   = run_start + run_len - XW'(1);
    cand_cx   = XW'(center_of(32'(run_start), 32'(run_len)));
    miss_next = (miss_cnt >= HOLD_M) ? miss_cnt : miss_cnt + MW'(1);
    revert    = (miss_next >= HOLD_M);
  end

  // Per-frame accumulation: run length/start, bounding box of qualifying
  // runs and the longest run seen so far (earlier run wins ties).
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      run_len   <= '0;
      run_start <= '0;
      best_len  <= '0;
      best_cx   <= '0;
      best_y    <= '0;
      acc_any   <= 1'b0;
      acc_x0    <= '0;
      acc_x1    <= '0;
      acc_y0    <= '0;
      acc_y1    <= '0;
    end else if (clear) begin
      run_len   <= '0;
      run_start <= '0;
      best_len  <= '0;
      best_cx   <= '0;
      best_y    <= '0;
      acc_any   <= 1'b0;
      acc_x0    <= '0;
      acc_x1    <= '0;
      acc_y0    <= '0;
      acc_y1    <= '0;
    end else begin
      if (extend) begin
        if (run_len == '0) run_start <= x_cont;
        if (run_len != '1) run_len <= run_len + XW'(1);
      end else if (in_line) begin
        run_len <= '0;
      end
      if (qualify) begin
        acc_any <= 1'b1;
        if (!acc_any || run_start < acc_x0) acc_x0 <= run_start;
        if (!acc_any || run_end > acc_x1)   acc_x1 <= run_end;
        if (!acc_any || y_cont < acc_y0)    acc_y0 <= y_cont;
        if (!acc_any || y_cont > acc_y1)    acc_y1 <= y_cont;
        if (run_len > best_len) begin
          best_len <= run_len;
          best_cx  <= cand_cx;
          best_y   <= y_cont;
        end
      end
    end
  end

  // Published results: load on a frame with a qualifying run, otherwise
  // hold until enough consecutive empty frames, then fall back to defaults.
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      found    <= 1'b0;
      center_x <= DEF_CX;
      center_y <= DEF_CY;
      max_run  <= '0;
      bbox_x0  <= DEF_CX;
      bbox_x1  <= DEF_CX;
      bbox_y0  <= DEF_CY;
      bbox_y1  <= DEF_CY;
      miss_cnt <= '0;
    end else if (publish) begin
      if (acc_any) begin
        found    <= 1'b1;
        miss_cnt <= '0;
        center_x <= best_cx;
        center_y <= best_y;
        max_run  <= best_len;
        bbox_x0  <= acc_x0;
        bbox_x1  <= acc_x1;
        bbox_y0  <= acc_y0;
        bbox_y1  <= acc_y1;
      end else begin
        found    <= 1'b0;
        miss_cnt <= miss_next;
        if (revert) begin
          center_x <= DEF_CX;
          center_y <= DEF_CY;
          max_run  <= '0;
          bbox_x0  <= DEF_CX;
          bbox_x1  <= DEF_CX;
          bbox_y0  <= DEF_CY;
          bbox_y1  <= DEF_CY;
        end
      end
    end
  end

endmodule

// File: rtl/color_blob_tracker.sv
// color_blob_tracker
// Finds, per frame and per colour channel, the longest horizontal run of
// mask pixels (its centre, line and length) and the bounding box of all
// qualifying runs. Results publish once per frame at the end of active video.
// Ports:
//   VGA_clock, reset           pixel clock, asynchronous active-low reset
//   mask[NUM_CH]               per-channel colour bit, aligned with x/y_cont
//   x_cont, y_cont             current raster position
//   iVgaHRequest/iVgaVRequest  active-pixel / active-line qualifiers
//   frame_done                 one-cycle pulse when the outputs update
//   found, center_x/y, max_run, bbox_*   packed results, channel 0 in LSBs
module color_blob_tracker
  import color_blob_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int H_ACTIVE    = DEFAULT_H_ACTIVE,
  parameter int V_ACTIVE    = DEFAULT_V_ACTIVE,
  parameter int MIN_RUN     = 4,
  parameter int HOLD_FRAMES = 3
) (
  input  logic                 VGA_clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    mask,
  input  logic [XW-1:0]        x_cont,
  input  logic [YW-1:0]        y_cont,
  input  logic                 iVgaHRequest,
  input  logic                 iVgaVRequest,
  output logic                 frame_done,
  output logic [NUM_CH-1:0]    found,
  output logic [NUM_CH*XW-1:0] center_x,
  output logic [NUM_CH*YW-1:0] center_y,
  output logic [NUM_CH*XW-1:0] max_run,
  output logic [NUM_CH*XW-1:0] bbox_x0,
  output logic [NUM_CH*XW-1:0] bbox_x1,
  output logic [NUM_CH*YW-1:0] bbox_y0,
  output logic [NUM_CH*YW-1:0] bbox_y1
);

  frame_state_t state, state_next;
  logic clear, in_line, publish, line_active;

  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_next;
  end

  // SYNC waits out any partial frame after reset so the first publish
  // always covers a complete frame.
  always_comb begin
    state_next  = state;
    clear       = 1'b0;
    in_line     = 1'b0;
    publish     = 1'b0;
    line_active = iVgaHRequest && iVgaVRequest;
    unique case (state)
      SYNC: begin
        if (!iVgaVRequest) state_next = IDLE;
      end
      IDLE: begin
        clear = 1'b1;
        if (iVgaVRequest) state_next = LINE_WAIT;
      end
      LINE_WAIT: begin
        if (!iVgaVRequest)     state_next = PUBLISH;
        else if (iVgaHRequest) state_next = IN_LINE;
      end
      IN_LINE: begin
        in_line = 1'b1;
        if (!line_active) state_next = LINE_WAIT;
      end
      PUBLISH: begin
        publish    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = SYNC;
    endcase
  end

  // Registered so the pulse rises on the same edge the results change.
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) frame_done <= 1'b0;
    else        frame_done <= publish;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    blob_channel #(
      .XW          (XW),
      .YW          (YW),
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .MIN_RUN     (MIN_RUN),
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_channel (
      .VGA_clock   (VGA_clock),
      .reset       (reset),
      .clear       (clear),
      .in_line     (in_line),
      .line_active (line_active),
      .publish     (publish),
      .mask_bit    (mask[ch]),
      .x_cont      (x_cont),
      .y_cont      (y_cont),
      .found       (found[ch]),
      .center_x    (center_x[ch*XW +: XW]),
      .center_y    (center_y[ch*YW +: YW]),
      .max_run     (max_run[ch*XW +: XW]),
      .bbox_x0     (bbox_x0[ch*XW +: XW]),
      .bbox_x1     (bbox_x1[ch*XW +: XW]),
      .bbox_y0     (bbox_y0[ch*YW +: YW]),
      .bbox_y1     (bbox_y1[ch*YW +: YW])
    );
  end

endmodule

// File: doc/color_blob_tracker.md
# color_blob_tracker

Multi-channel successor to the single-colour red-object locator. It consumes NUM_CH pre-filtered 1-bit colour masks, in raster order alongside the VGA scan counters. For each channel it finds, per video frame:
- the longest horizontal run of mask pixels and that run's centre;
- the bounding box of all qualifying runs.

Results publish once per frame at the end of active video and drive overlay and game logic downstream of the 3x3 filter stage.

## Interface
Parameters:
- NUM_CH, 2, number of independent colour channels
- XW, 10, x coordinate / run-length width
- YW, 9, y coordinate width
- H_ACTIVE, 640, active pixels per line; default centre x = H_ACTIVE/2
- V_ACTIVE, 480, active lines; default centre y = V_ACTIVE/2
- MIN_RUN, 4, minimum run length counted as an object (1..2^XW-1)
- HOLD_FRAMES, 3, consecutive empty frames before a channel's centre reverts to default (0 = revert immediately)

Ports:
- VGA_clock  in  1  pixel clock
- reset  in  1  asynchronous, active-low
- mask  in  NUM_CH  per-channel filtered colour bit, aligned with x_cont/y_cont
- x_cont  in  XW  current pixel column
- y_cont  in  YW  current line
- iVgaHRequest  in  1  high during active pixels of a line
- iVgaVRequest  in  1  high during active lines of a frame
- frame_done  out  1  one-cycle pulse when outputs update
- found  out  NUM_CH  channel had at least one qualifying run last frame
- center_x  out  NUM_CH*XW  longest-run centre column, channel 0 in LSBs
- center_y  out  NUM_CH*YW  longest-run line
- max_run  out  NUM_CH*XW  longest-run length
- bbox_x0, bbox_x1  out  NUM_CH*XW  min/max column of qualifying runs
- bbox_y0, bbox_y1  out  NUM_CH*YW  min/max line of qualifying runs

## Operation
Reset values:
- frame_done = 0, found = 0, max_run = 0
- center_x = H_ACTIVE/2, center_y = V_ACTIVE/2
- bbox_x0 = bbox_x1 = H_ACTIVE/2, bbox_y0 = bbox_y1 = V_ACTIVE/2
- all miss counters = 0
- FSM in SYNC

Shared frame FSM:
- SYNC: wait for iVgaVRequest low. This prevents publishing a partial frame after reset. Go to IDLE.
- IDLE: clear all per-frame accumulators. On iVgaVRequest high go to LINE_WAIT.
- LINE_WAIT: iVgaVRequest low -> PUBLISH. iVgaHRequest high -> IN_LINE.
- IN_LINE: per-channel run tracking active. iVgaHRequest low -> LINE_WAIT; any open run closes this cycle.
- PUBLISH: one cycle. Update outputs, pulse frame_done, go to IDLE.

Per-channel run tracking:
- In IN_LINE, mask=1: run_len increments, saturating at 2^XW-1. The first pixel of a run latches run_start = x_cont.
- A run closes when mask=0 in IN_LINE, or when IN_LINE exits.
- On close, if run_len >= MIN_RUN, the run qualifies:
  - bbox min/max update with run_start, run_start+run_len-1 and y_cont.
  - If run_len > best_len (strictly greater, so the earlier run wins ties), latch best_len, best_cx = run_start + ((run_len-1)>>1), best_y = y_cont.
- Runs shorter than MIN_RUN are discarded.
- Arithmetic is XW bits unsigned. Saturated runs still compute the centre with the saturated length.

PUBLISH, per channel:
- If any qualifying run occurred: found=1, miss counter=0, all result outputs loaded from the accumulators.
- Otherwise: found=0, miss counter increments (saturating).
  - If the counter reaches HOLD_FRAMES, centre and bbox revert to defaults and max_run=0.
  - Otherwise the previous centre, bbox and max_run are held.

## Timing
- The mask bit is consumed in the same cycle as its x_cont/y_cont. The caller compensates for filter latency.
- Run close is evaluated in the cycle mask falls. A pixel at x_cont=N with mask=0 ends a run whose last pixel was N-1.
- PUBLISH is the cycle after iVgaVRequest is sampled low in LINE_WAIT. Outputs change on the same edge that raises frame_done.
- Outputs are stable for a whole frame between pulses.
- If iVgaVRequest falls while in IN_LINE (no horizontal blank), the run closes first, then PUBLISH follows via LINE_WAIT on the next cycle.
- Asynchronous reset mid-frame returns the FSM to SYNC. No frame_done occurs until one full frame has been observed.

## Structure
- Package color_blob_pkg holds:
  - the FSM state encoding (SYNC, IDLE, LINE_WAIT, IN_LINE, PUBLISH);
  - localparams for default centre values;
  - a helper function for the centre computation.
- Sub-module blob_channel implements run tracking, the accumulators and the hold/miss logic for one channel. The top level holds the shared FSM and a generate loop of NUM_CH instances.

## Test plan
- Single 20-pixel run, ch0, x 100..119 on line 50; MIN_RUN=4 -> center_x=109, center_y=50, max_run=20, bbox 100..119 / 50..50, found=01, one frame_done pulse.
- Run of 3 pixels only -> found=0; outputs hold the previous frame's values until HOLD_FRAMES=3 empty frames, then centre reverts to 320/240 and max_run=0.
- Two equal 30-pixel runs on lines 10 and 200 -> center_y=10 (first wins). Bbox spans y 10..200.
- Run touching x=639 with iVgaHRequest falling -> the run closes at line end. No spill into the next line's count.
- Distinct blobs on ch0 and ch1 in the same frame -> independent results, correctly packed (ch1 in upper fields).
- Assert reset at line 240 mid-run -> all outputs at reset values. The remainder of that frame produces no frame_done. The next full frame publishes correctly.
